// File: rtl/tart_sched_pkg.sv
// Shared opcodes and state encodings for the correlator frame scheduler.
package tart_sched_pkg;

  localparam logic [7:0] CMD_START  = 8'h01;
  localparam logic [7:0] CMD_STOP   = 8'h02;
  localparam logic [7:0] CMD_CLEAR  = 8'h03;
  localparam logic [7:0] CMD_SETLEN = 8'h10;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StAcq,
    StHold
  } sched_state_e;

  typedef enum logic [1:0] {
    PsCmd,
    PsLen2,
    PsLen1,
    PsLen0
  } parse_state_e;

endpackage

// File: rtl/sched_cmd_parser.sv
// Byte-stream command decoder: emits start/stop/clear pulses and a 24-bit length update.
module sched_cmd_parser
  import tart_sched_pkg::*;
(
  input  logic        clock,
  input  logic        areset_n,
  input  logic        byte_valid_i,
  input  logic        byte_last_i,
  input  logic [7:0]  byte_data_i,
  output logic        start_o,
  output logic        stop_o,
  output logic        clear_o,
  output logic        len_valid_o,
  output logic [23:0] len_value_o
);

  parse_state_e state_q, state_d;
  logic [7:0]   len_hi_q, len_hi_d;
  logic [7:0]   len_mid_q, len_mid_d;

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= PsCmd;
      len_hi_q  <= '0;
      len_mid_q <= '0;
    end else begin
      state_q   <= state_d;
      len_hi_q  <= len_hi_d;
      len_mid_q <= len_mid_d;
    end
  end

  assign len_value_o = {len_hi_q, len_mid_q, byte_data_i};

  // A tlast before the final length byte abandons the partial length.
  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    len_mid_d   = len_mid_q;
    start_o     = 1'b0;
    stop_o      = 1'b0;
    clear_o     = 1'b0;
    len_valid_o = 1'b0;
    if (byte_valid_i) begin
      unique case (state_q)
        PsCmd: begin
          case (byte_data_i)
            CMD_START:  start_o = 1'b1;
            CMD_STOP:   stop_o  = 1'b1;
            CMD_CLEAR:  clear_o = 1'b1;
            CMD_SETLEN: if (!byte_last_i) state_d = PsLen2;
            default:    ;
          endcase
        end
        PsLen2: begin
          len_hi_d = byte_data_i;
          state_d  = byte_last_i ? PsCmd : PsLen1;
        end
        PsLen1: begin
          len_mid_d = byte_data_i;
          state_d   = byte_last_i ? PsCmd : PsLen0;
        end
        PsLen0: begin
          len_valid_o = 1'b1;
          state_d     = PsCmd;
        end
      endcase
    end
  end

endmodule

// File: rtl/correlator_scheduler.sv
// Frame scheduler for the capture/acquire/correlate datapath with bank-swap handshaking.
module correlator_scheduler
  import tart_sched_pkg::*;
#(
  parameter int unsigned              LEN_BITS     = 24,
  parameter logic [LEN_BITS-1:0]      LEN_DEFAULT  = LEN_BITS'(16368),
  parameter int unsigned              FCNT_BITS    = 16,
  parameter int unsigned              LOCK_TIMEOUT = 1023
) (
  input  logic                 clock,
  input  logic                 areset_n,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic                 s_tlast,
  input  logic [7:0]           s_tdata,
  input  logic                 sig_locked_i,
  input  logic                 sig_strobe_i,
  input  logic                 visibility_i,
  output logic                 capture_en_o,
  output logic                 acquire_en_o,
  output logic                 correlator_o,
  output logic                 swap_o,
  output logic [FCNT_BITS-1:0] frame_count_o,
  output logic                 overflow_o,
  output logic                 busy_o
);

  localparam int unsigned TmoBits = $clog2(LOCK_TIMEOUT + 1);

  logic        cmd_start, cmd_stop, cmd_clear, len_valid;
  logic [23:0] len_value;

  sched_state_e         state_q, state_d;
  logic [LEN_BITS-1:0]  cnt_q, cnt_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [LEN_BITS-1:0]  acc_len_q, acc_len_d;
  logic [FCNT_BITS-1:0] fcnt_q, fcnt_d;
  logic [TmoBits-1:0]   tmo_q, tmo_d;
  logic                 ovf_q, ovf_d;
  logic                 swap_q, swap_d;
  logic [LEN_BITS-1:0]  eff_len;
  logic                 frame_end;

  assign s_tready = 1'b1;

  sched_cmd_parser u_parser (
    .clock        (clock),
    .areset_n     (areset_n),
    .byte_valid_i (s_tvalid),
    .byte_last_i  (s_tlast),
    .byte_data_i  (s_tdata),
    .start_o      (cmd_start),
    .stop_o       (cmd_stop),
    .clear_o      (cmd_clear),
    .len_valid_o  (len_valid),
    .len_value_o  (len_value)
  );

  // A programmed length of zero behaves as one strobe per frame.
  assign eff_len   = (acc_len_q == '0) ? LEN_BITS'(1) : acc_len_q;
  assign frame_end = sig_strobe_i && (cnt_q == len_q - LEN_BITS'(1));

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      len_q     <= LEN_DEFAULT;
      acc_len_q <= LEN_DEFAULT;
      fcnt_q    <= '0;
      tmo_q     <= '0;
      ovf_q     <= 1'b0;
      swap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      acc_len_q <= acc_len_d;
      fcnt_q    <= fcnt_d;
      tmo_q     <= tmo_d;
      ovf_q     <= ovf_d;
      swap_q    <= swap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    acc_len_d = acc_len_q;
    fcnt_d    = fcnt_q;
    tmo_d     = tmo_q;
    ovf_d     = ovf_q;
    swap_d    = 1'b0;
    if (len_valid) acc_len_d = LEN_BITS'(len_value);

    unique case (state_q)
      StIdle: begin
        if (cmd_start) begin
          state_d = StArm;
          cnt_d   = '0;
          tmo_d   = '0;
          len_d   = eff_len;
          fcnt_d  = '0;
        end
      end
      StArm: begin
        if (cmd_stop) begin
          state_d = StIdle;
        end else if (sig_locked_i) begin
          state_d = StAcq;
          cnt_d   = '0;
          len_d   = eff_len;
        end else if (tmo_q == TmoBits'(LOCK_TIMEOUT)) begin
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoBits'(1);
        end
      end
      StAcq: begin
        if (cmd_stop) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (!sig_locked_i) begin
          state_d = StArm;
          cnt_d   = '0;
          tmo_d   = '0;
        end else if (frame_end) begin
          cnt_d = '0;
          if (visibility_i) begin
            swap_d = 1'b1;
            fcnt_d = fcnt_q + FCNT_BITS'(1);
            len_d  = eff_len;
          end else begin
            ovf_d   = 1'b1;
            state_d = StHold;
          end
        end else if (sig_strobe_i) begin
          cnt_d = cnt_q + LEN_BITS'(1);
        end
      end
      StHold: begin
        if (cmd_stop) begin
          state_d = StIdle;
        end else if (!sig_locked_i) begin
          state_d = StArm;
          tmo_d   = '0;
        end else if (visibility_i) begin
          state_d = StAcq;
          swap_d  = 1'b1;
          fcnt_d  = fcnt_q + FCNT_BITS'(1);
          cnt_d   = '0;
          len_d   = eff_len;
        end
      end
      default: state_d = StIdle;
    endcase

    // CLEAR takes precedence over a coincident frame completion.
    if (cmd_clear) begin
      ovf_d  = 1'b0;
      fcnt_d = '0;
    end
  end

  assign capture_en_o  = (state_q != StIdle);
  assign acquire_en_o  = (state_q == StAcq);
  assign correlator_o  = (state_q == StAcq);
  assign busy_o        = (state_q != StIdle);
  assign swap_o        = swap_q;
  assign frame_count_o = fcnt_q;
  assign overflow_o    = ovf_q;

endmodule
